alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//   Register-file front end for the 8-bit combinational alu block. Accepts one command
//   at a time over a valid/ready handshake and reads operands from a small register file.
//   Drives the alu inputs from registers, captures the alu result and writes it back.
//   Sits between the command source (testbench/controller) and the alu, on a single clock.
// PARAMETERS
//   NREG  4  number of 8-bit registers; power of 2, >=2; AW = $clog2(NREG)
// PORTS
//   clk_i         in   1   clock, all state on rising edge
//   rst_i         in   1   reset, asynchronous, active-high
//   cmd_valid_i   in   1   command present
//   cmd_ready_o   out  1   sequencer can accept command (1 only in IDLE)
//   cmd_op_i      in   3   alu opcode, passed unchanged to alu_op_o
//   cmd_load_i    in   1   1 = load cmd_imm_i into rd, alu not used
//   cmd_imm_en_i  in   1   1 = B operand is cmd_imm_i instead of reg[rs2]
//   cmd_imm_i     in   8   immediate data
//   cmd_rd_i      in   AW  destination register
//   cmd_rs1_i     in   AW  A-operand register
//   cmd_rs2_i     in   AW  B-operand register
//   alu_a_o       out  8   registered A operand to alu
//   alu_b_o       out  8   registered B operand to alu
//   alu_op_o      out  3   registered opcode to alu
//   alu_res_i     in   8   combinational result from alu
//   done_o        out  1   one-cycle pulse: result valid, writeback this cycle
//   res_o         out  8   result of last completed command (held until next done)
//   zero_o        out  1   res_o == 0, updated with res_o
//   dbg_addr_i    in   AW  debug read address
//   dbg_data_o    out  8   reg[dbg_addr_i], combinational
// BEHAVIOUR
//   Reset (async, rst_i=1): state=IDLE; all regs, alu_a_o, alu_b_o, alu_op_o, res_o = 0;
//     done_o=0, zero_o=0. Reset mid-command aborts it: no writeback, no done_o pulse.
//   FSM states IDLE, EXEC, WB. cmd_ready_o = (state==IDLE).
//   Accept = cmd_valid_i & cmd_ready_o at rising edge E0. All cmd fields sampled at E0 only.
//   IDLE, accept, cmd_load_i=0: alu_a_o<=reg[rs1]; alu_b_o<=imm_en?imm:reg[rs2];
//     alu_op_o<=op; latch rd -> EXEC.
//   IDLE, accept, cmd_load_i=1: result<=cmd_imm_i, latch rd -> WB; alu_* unchanged.
//   EXEC (1 cycle): at E1 result<=alu_res_i -> WB.
//   WB (1 cycle): done_o=1 (decoded from state); res_o/zero_o already hold the new result.
//     At the edge ending WB, reg[rd]<=result -> IDLE.
//   res_o, zero_o: loaded at the same edge that enters WB.
//   Latency: alu cmd: done_o high 2 cycles after the accept edge. Load: 1 cycle.
//   Throughput: one alu cmd per 3 cycles, one load per 2 cycles. No pipelining.
//   Hazards: the next cmd is read in IDLE after writeback, so rd->rs forwarding is unneeded.
//   cmd_valid_i held high while busy: cmd is stalled, not dropped; accepted in first IDLE cycle.
//   Arithmetic: sequencer does none. 8-bit wrap, shift semantics and all 8 opcodes are
//     defined by alu. Opcodes 110/111 are passed through unchanged.
//   rd==rs1==rs2 is legal: operands are read before writeback.
//   dbg_data_o shows old reg[rd] during WB and new value from the following cycle.
// TESTING
//   1 reset: assert rst_i off-edge -> all outputs 0 immediately, cmd_ready_o=1 after release
//   2 load r1=0x05, r2=0x03 -> done_o 1 cycle after each accept; dbg r1=05, r2=03
//   3 ADD(000) r3=r1+r2 -> alu_a_o=05, alu_b_o=03; done_o 2 cycles later, res_o=08, zero_o=0, r3=08
//   4 SUB r0=r2-r2 -> res_o=00, zero_o=1; SUB r0=r2-r1 -> res_o=FE (wrap), zero_o=0
//   5 XOR r1, imm_en=1, imm=FF -> res_o=FA; SHL(110) imm=08 -> res_o=00, zero_o=1
//   6 valid held high, ADD r3=r3+r3 then ADD r2=r3+r2 -> 2nd accepted 1st IDLE cycle after
//     WB, reads r3=10, res_o=13; rst_i during EXEC -> no done_o, all regs cleared to 0

Source files
------------

// File: rtl/alu_sequencer.sv
// Register-file front end for the 8-bit combinational alu: accepts one command at a
// time, drives registered operands to the alu, captures its result and writes it back.
module alu_sequencer #(
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [2:0]    cmd_op_i,
  input  logic          cmd_load_i,
  input  logic          cmd_imm_en_i,
  input  logic [7:0]    cmd_imm_i,
  input  logic [AW-1:0] cmd_rd_i,
  input  logic [AW-1:0] cmd_rs1_i,
  input  logic [AW-1:0] cmd_rs2_i,
  output logic [7:0]    alu_a_o,
  output logic [7:0]    alu_b_o,
  output logic [2:0]    alu_op_o,
  input  logic [7:0]    alu_res_i,
  output logic          done_o,
  output logic [7:0]    res_o,
  output logic          zero_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [7:0]    dbg_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      regFile_q [NREG];
  logic [7:0]      aluA_q, aluA_d;
  logic [7:0]      aluB_q, aluB_d;
  logic [2:0]      aluOp_q, aluOp_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [7:0]      result_q, result_d;
  logic            zero_q, zero_d;
  logic            wrEn;

  // The result register doubles as res_o, so writeback simply copies it into reg[rd].
  always_comb begin
    state_d  = state_q;
    aluA_d   = aluA_q;
    aluB_d   = aluB_q;
    aluOp_d  = aluOp_q;
    rd_d     = rd_q;
    result_d = result_q;
    zero_d   = zero_q;
    wrEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          rd_d = cmd_rd_i;
          if (cmd_load_i) begin
            result_d = cmd_imm_i;
            zero_d   = (cmd_imm_i == 8'h00);
            state_d  = WB;
          end else begin
            aluA_d  = regFile_q[cmd_rs1_i];
            aluB_d  = cmd_imm_en_i ? cmd_imm_i : regFile_q[cmd_rs2_i];
            aluOp_d = cmd_op_i;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        result_d = alu_res_i;
        zero_d   = (alu_res_i == 8'h00);
        state_d  = WB;
      end
      WB: begin
        wrEn    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      aluA_q   <= 8'h00;
      aluB_q   <= 8'h00;
      aluOp_q  <= 3'b000;
      rd_q     <= '0;
      result_q <= 8'h00;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      aluOp_q  <= aluOp_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regFile_q[i] <= 8'h00;
      end
    end else if (wrEn) begin
      regFile_q[rd_q] <= result_q;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign done_o      = (state_q == WB);
  assign alu_a_o     = aluA_q;
  assign alu_b_o     = aluB_q;
  assign alu_op_o    = aluOp_q;
  assign res_o       = result_q;
  assign zero_o      = zero_q;
  assign dbg_data_o  = regFile_q[dbg_addr_i];

endmodule
